// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the five-stage pipeline.
package cpu_pkg;
   localparam int XLEN   = 64;
   localparam int REG_AW = 5;

   typedef enum logic [0:0] {IDLE, ACCESS} mem_state_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   loadedData;
      logic [XLEN-1:0]   results;
      logic              memToReg;
      logic              regWrite;
   } mem_wb_t;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB pipeline register; a bubble clears the whole entry.
module mem_wb_reg
   import cpu_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       bubble_i,
   input  logic [$bits(mem_wb_t)-1:0] d_i,
   output logic [$bits(mem_wb_t)-1:0] q_o
);
   logic [$bits(mem_wb_t)-1:0] q_q;

   // Load the next entry every cycle, or all zeros for a bubble or reset.
   always_ff @(posedge clk)
      if (!rst_n || bubble_i) q_q <= '0;
      else q_q <= d_i;

   assign q_o = q_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage with req/ack data-memory handshake and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort an access after TIMEOUT_CYCLES cycles without DmAck.
module mem_access_stage
   import cpu_pkg::*;
#(
   parameter int XLEN           = cpu_pkg::XLEN,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ExValid,
   input  logic [XLEN-1:0]   ExResult,
   input  logic [XLEN-1:0]   ExStoreData,
   input  logic [REG_AW-1:0] ExReg,
   input  logic              ExMemRead,
   input  logic              ExMemWrite,
   input  logic              ExMemToReg,
   input  logic              ExRegWrite,
   output logic              MemStall,
   output logic              DmReq,
   output logic              DmWe,
   output logic [XLEN-1:0]   DmAddr,
   output logic [XLEN-1:0]   DmWData,
   input  logic              DmAck,
   input  logic [XLEN-1:0]   DmRData,
   output logic              WbValid,
   output logic [REG_AW-1:0] Reg,
   output logic [XLEN-1:0]   loadedData,
   output logic [XLEN-1:0]   Results,
   output logic              MemToReg,
   output logic              RegWrite,
   output logic              MemErr
);
`ifdef MEM_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int CW = (TIMEOUT_CYCLES > 256) ? $clog2(TIMEOUT_CYCLES) : 8;

   mem_state_t        state_q, state_d;
   logic [XLEN-1:0]   addr_q, addr_d, wdata_q, wdata_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              we_q, we_d, m2r_q, m2r_d, rw_q, rw_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              err_q;
   logic              tmo, done, bubble, accept_mem;
   mem_wb_t           wb_d, wb_q;

   assign accept_mem = state_q == IDLE && ExValid && (ExMemRead || ExMemWrite);
   assign tmo        = TMO_EN && state_q == ACCESS && !DmAck && cnt_q == CW'(TIMEOUT_CYCLES - 1);
   assign done       = state_q == ACCESS && (DmAck || tmo);
   assign MemStall   = rst_n && (accept_mem || (state_q == ACCESS && !done));

   // Next state, access latches and the entry offered to MEM/WB.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      we_d    = we_q;
      m2r_d   = m2r_q;
      rw_d    = rw_q;
      cnt_d   = '0;
      wb_d    = '0;
      bubble  = 1'b1;
      if (accept_mem) begin
         state_d = ACCESS;
         addr_d  = ExResult;
         wdata_d = ExStoreData;
         rd_d    = ExReg;
         we_d    = ExMemWrite && !ExMemRead;
         m2r_d   = ExMemToReg;
         rw_d    = ExRegWrite;
      end else if (state_q == IDLE && ExValid) begin
         bubble = 1'b0;
         wb_d   = '{valid: 1'b1, rd: ExReg, loadedData: '0, results: ExResult,
                    memToReg: ExMemToReg, regWrite: ExRegWrite};
      end else if (state_q == ACCESS) begin
         cnt_d = cnt_q + 1'b1;
         if (done) begin
            state_d = IDLE;
            bubble  = 1'b0;
            wb_d    = '{valid: 1'b1, rd: rd_q, loadedData: (DmAck && !we_q) ? DmRData : '0,
                        results: addr_q, memToReg: m2r_q, regWrite: rw_q && !tmo};
         end
      end
   end

   // State and access registers; reset abandons any pending access.
   always_ff @(posedge clk)
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         m2r_q   <= 1'b0;
         rw_q    <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         m2r_q   <= m2r_d;
         rw_q    <= rw_d;
         cnt_q   <= cnt_d;
         err_q   <= tmo;
      end

   mem_wb_reg u_mem_wb (
      .clk      (clk),
      .rst_n    (rst_n),
      .bubble_i (bubble),
      .d_i      (wb_d),
      .q_o      (wb_q)
   );

   assign DmReq      = state_q == ACCESS;
   assign DmWe       = we_q;
   assign DmAddr     = addr_q;
   assign DmWData    = wdata_q;
   assign MemErr     = err_q;
   assign WbValid    = wb_q.valid;
   assign Reg        = wb_q.rd;
   assign loadedData = wb_q.loadedData;
   assign Results    = wb_q.results;
   assign MemToReg   = wb_q.memToReg;
   assign RegWrite   = wb_q.regWrite;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ExValid, ExMemRead, ExMemWrite, ExMemToReg, ExRegWrite, DmAck;
   logic [63:0] ExResult, ExStoreData, DmRData;
   logic [4:0]  ExReg;
   logic        MemStall, DmReq, DmWe, WbValid, MemToReg, RegWrite, MemErr;
   logic [63:0] DmAddr, DmWData, loadedData, Results;
   logic [4:0]  Reg;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          req_n, stall_n, err_n;
   logic        we_s;
   logic [63:0] addr_s, wd_s;

   always #5 clk = ~clk;

   mem_access_stage #(.XLEN(64), .TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .ExValid(ExValid), .ExResult(ExResult),
      .ExStoreData(ExStoreData), .ExReg(ExReg), .ExMemRead(ExMemRead),
      .ExMemWrite(ExMemWrite), .ExMemToReg(ExMemToReg), .ExRegWrite(ExRegWrite),
      .MemStall(MemStall), .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr),
      .DmWData(DmWData), .DmAck(DmAck), .DmRData(DmRData), .WbValid(WbValid),
      .Reg(Reg), .loadedData(loadedData), .Results(Results), .MemToReg(MemToReg),
      .RegWrite(RegWrite), .MemErr(MemErr)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic v, input logic rd, input logic wr, input logic m2r,
                          input logic rw, input logic [63:0] res, input logic [63:0] sd,
                          input logic [4:0] rg);
      ExValid = v; ExMemRead = rd; ExMemWrite = wr; ExMemToReg = m2r;
      ExRegWrite = rw; ExResult = res; ExStoreData = sd; ExReg = rg;
   endtask

   // Memory op already presented: acceptance cycle, then ack after k wait cycles.
   task automatic mem_op(input int k, input logic [63:0] rdata);
      req_n = 0; stall_n = 0; err_n = 0;
      for (int i = 0; i <= k + 1; i++) begin
         DmAck   = (i == k + 1);
         DmRData = (i == k + 1) ? rdata : 64'h0;
         #1;
         req_n   += int'(DmReq);
         stall_n += int'(MemStall);
         err_n   += int'(MemErr);
         if (i == k + 1) begin
            we_s = DmWe; addr_s = DmAddr; wd_s = DmWData;
         end
         step();
      end
      DmAck = 1'b0; DmRData = 64'h0;
      present(0, 0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
   endtask

   initial begin
      DmAck = 1'b0; DmRData = 64'h0;
      present(1, 1, 0, 1, 1, 64'h80, 64'h0, 5'd1);
      #1;
      chk("stall_in_reset", MemStall, 0);
      step(); step();
      present(0, 0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
      chk("rst_wbvalid", WbValid, 0);
      chk("rst_dmreq", DmReq, 0);
      chk("rst_results", Results, 0);
      chk("rst_reg", Reg, 0);
      chk("rst_memerr", MemErr, 0);
      rst_n = 1'b1;

      // ALU op
      present(1, 0, 0, 0, 1, 64'h1234, 64'h0, 5'd3);
      #1;
      chk("alu_stall", MemStall, 0);
      chk("alu_dmreq", DmReq, 0);
      step();
      chk("alu_wbvalid", WbValid, 1);
      chk("alu_results", Results, 64'h1234);
      chk("alu_reg", Reg, 3);
      chk("alu_regwrite", RegWrite, 1);
      chk("alu_loaded", loadedData, 0);
      present(0, 0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
      step();
      chk("alu_bubble", WbValid, 0);

      // Load, three wait cycles
      present(1, 1, 0, 1, 1, 64'h100, 64'h0, 5'd7);
      mem_op(3, 64'hDEADBEEF);
      chk("ld_req_cycles", req_n, 4);
      chk("ld_stall_cycles", stall_n, 4);
      chk("ld_addr", addr_s, 64'h100);
      chk("ld_we", we_s, 0);
      chk("ld_wbvalid", WbValid, 1);
      chk("ld_data", loadedData, 64'hDEADBEEF);
      chk("ld_memtoreg", MemToReg, 1);
      chk("ld_reg", Reg, 7);
      chk("ld_results", Results, 64'h100);
      chk("ld_dmreq_after", DmReq, 0);

      // Store, immediate ack, then ALU op right behind it
      present(1, 0, 1, 0, 0, 64'h200, 64'h55, 5'd0);
      mem_op(0, 64'hFFFF);
      chk("st_we", we_s, 1);
      chk("st_wdata", wd_s, 64'h55);
      chk("st_addr", addr_s, 64'h200);
      chk("st_wbvalid", WbValid, 1);
      chk("st_regwrite", RegWrite, 0);
      chk("st_loaded", loadedData, 0);
      present(1, 0, 0, 0, 1, 64'hAA, 64'h0, 5'd9);
      #1;
      chk("st_next_stall", MemStall, 0);
      step();
      chk("st_next_wbvalid", WbValid, 1);
      chk("st_next_results", Results, 64'hAA);

      // Read and write both set: treated as a load
      present(1, 1, 1, 1, 1, 64'h300, 64'h99, 5'd4);
      mem_op(1, 64'h3C3C);
      chk("rw_we", we_s, 0);
      chk("rw_data", loadedData, 64'h3C3C);
      chk("rw_wbvalid", WbValid, 1);

      // Back-to-back zero-wait loads
      req_n = 0;
      for (int i = 0; i < 4; i++) begin
         present(1, 1, 0, 1, 1, (i < 2) ? 64'h400 : 64'h408, 64'h0, (i < 2) ? 5'd10 : 5'd11);
         DmAck   = i[0];
         DmRData = (i < 2) ? 64'hA1 : 64'hB2;
         #1;
         req_n += int'(DmReq);
         step();
         chk($sformatf("b2b_wbvalid%0d", i), WbValid, i[0]);
         if (i == 1) chk("b2b_data_a", loadedData, 64'hA1);
         if (i == 3) chk("b2b_data_b", loadedData, 64'hB2);
      end
      DmAck = 1'b0; DmRData = 64'h0;
      present(0, 0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
      chk("b2b_req_cycles", req_n, 2);
      step();
      chk("b2b_no_dup_wb", WbValid, 0);
      chk("b2b_no_dup_req", DmReq, 0);

      // Reset in second ACCESS cycle
      present(1, 1, 0, 1, 1, 64'h500, 64'h0, 5'd12);
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("rstacc_stall", MemStall, 0);
      step();
      chk("rstacc_dmreq", DmReq, 0);
      chk("rstacc_wbvalid", WbValid, 0);
      chk("rstacc_addr", DmAddr, 0);
      chk("rstacc_regwrite", RegWrite, 0);
      rst_n = 1'b1;
      present(0, 0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
      DmAck = 1'b1;
      step();
      chk("idle_ack_wbvalid", WbValid, 0);
      chk("idle_ack_dmreq", DmReq, 0);
      DmAck = 1'b0;

`ifdef MEM_TIMEOUT_EN
      // No ack: abort after four ACCESS cycles
      present(1, 1, 0, 1, 1, 64'h600, 64'h0, 5'd5);
      req_n = 0;
      for (int i = 0; i < 5; i++) begin
         #1;
         req_n += int'(DmReq);
         chk($sformatf("to_err_early%0d", i), MemErr, 0);
         step();
      end
      present(0, 0, 0, 0, 0, 64'h0, 64'h0, 5'd0);
      chk("to_req_cycles", req_n, 4);
      chk("to_memerr", MemErr, 1);
      chk("to_wbvalid", WbValid, 1);
      chk("to_regwrite", RegWrite, 0);
      chk("to_reg", Reg, 5);
      chk("to_dmreq", DmReq, 0);
      step();
      chk("to_memerr_pulse", MemErr, 0);
      chk("to_idle_wbvalid", WbValid, 0);
`else
      // No timeout: a long wait still completes normally
      present(1, 1, 0, 1, 1, 64'h600, 64'h0, 5'd5);
      mem_op(8, 64'h77);
      chk("nto_req_cycles", req_n, 9);
      chk("nto_stall_cycles", stall_n, 9);
      chk("nto_memerr", err_n, 0);
      chk("nto_data", loadedData, 64'h77);
      chk("nto_regwrite", RegWrite, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the 64-bit five-stage pipeline: takes the EX-stage result and control bits, performs at most one data-memory load or store over a request/acknowledge handshake, and registers the outcome into the MEM/WB boundary. Its outputs feed the write-back stage directly: register number, loaded data, ALU result, MemToReg and RegWrite. Variable-latency memory is absorbed by stalling the upstream stage.

## Interface
Parameters:
- XLEN, 64, datapath and address width
- TIMEOUT_CYCLES, 255, access-abort limit; used only with MEM_TIMEOUT_EN

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- ExValid  in  1  EX/MEM register holds a real instruction
- ExResult  in  XLEN  ALU result; the memory address for loads and stores
- ExStoreData  in  XLEN  store data
- ExReg  in  5  destination register
- ExMemRead, ExMemWrite, ExMemToReg, ExRegWrite  in  1 each  control bits
- MemStall  out  1  upstream must hold the EX/MEM register (combinational)
- DmReq  out  1  data-memory request
- DmWe  out  1  1 = store, 0 = load
- DmAddr  out  XLEN  access address
- DmWData  out  XLEN  store data
- DmAck  in  1  memory completed the request this cycle
- DmRData  in  XLEN  load data; valid while DmAck = 1
- WbValid  out  1  MEM/WB register holds a real instruction
- Reg  out  5  destination register to write-back
- loadedData  out  XLEN  load result
- Results  out  XLEN  ALU result forwarded to write-back
- MemToReg, RegWrite  out  1 each  control bits to write-back
- MemErr  out  1  one-cycle pulse when an access times out

## Operation
- Two states: IDLE and ACCESS.
- IDLE, ExValid = 1, no memory op:
  - copy ExReg, ExResult, ExMemToReg and ExRegWrite into the MEM/WB register.
  - Set WbValid = 1 and loadedData = 0.
  - MemStall = 0.
- IDLE, ExValid = 1, ExMemRead or ExMemWrite:
  - MemStall = 1.
  - Latch the address, store data, DmWe and the control bits internally.
  - Go to ACCESS; the MEM/WB register loads a bubble (WbValid = 0, RegWrite = 0).
- IDLE, ExValid = 0: load a bubble.
- ExMemRead and ExMemWrite both set is illegal. Treat it as a load (DmWe = 0) and ignore the write.
- ACCESS:
  - DmReq = 1, with DmWe, DmAddr and DmWData held stable until DmAck.
  - MemStall = !DmAck.
  - Keep loading bubbles into MEM/WB while waiting.
- ACCESS with DmAck = 1:
  - MEM/WB takes the latched fields; loadedData = DmRData for a load, 0 for a store.
  - Set WbValid = 1 and go to IDLE.
  - The upstream register advances on the same edge. The instruction still presented that cycle is not re-accepted.
- RegWrite and MemToReg pass through unchanged. Control decode guarantees RegWrite = 0 for stores.

## Timing
- Reset (rst_n = 0 at an edge): state goes to IDLE.
  - WbValid, Reg, loadedData, Results, MemToReg, RegWrite, DmReq, DmWe, DmAddr, DmWData and MemErr all reset to 0.
  - MemStall is 0 while in reset.
- Non-memory instruction: one cycle from EX/MEM to valid MEM/WB.
- Memory instruction with DmAck arriving k cycles after DmReq first rises (k ≥ 0; k = 0 means acknowledged in the first ACCESS cycle): valid MEM/WB appears k + 2 edges after acceptance.
- Back-to-back zero-wait loads: one instruction every 2 cycles.
- Reset during ACCESS: DmReq drops at that edge and the pending instruction is discarded with no write-back.
- DmAck seen in IDLE: ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter runs while in ACCESS.
  - After TIMEOUT_CYCLES cycles with no DmAck, DmReq drops and MemErr pulses for one cycle.
  - MEM/WB gets the instruction with RegWrite = 0 and WbValid = 1, and the state returns to IDLE.
- MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely and MemErr is tied to 0.

## Structure
- Shared package cpu_pkg holds:
  - the XLEN and REG_AW = 5 constants
  - the mem_state_t enum (IDLE, ACCESS)
  - a mem_wb_t struct (valid, reg, loadedData, results, memToReg, regWrite)
- One sub-module, mem_wb_reg: the MEM/WB pipeline register, with synchronous active-low reset and a bubble-load input.

## Test plan
- ALU op, ExResult = 64'h1234, ExReg = 3, RegWrite = 1 -> next cycle WbValid = 1, Results = 64'h1234, Reg = 3, MemStall never high.
- Load from 64'h100 with DmAck after 3 wait cycles and DmRData = 64'hDEADBEEF -> DmReq high 4 cycles; MemStall high 4 cycles, including the acceptance cycle; loadedData = 64'hDEADBEEF with MemToReg = 1 one edge after the ack.
- Store of 64'h55 to 64'h200 with immediate ack -> DmWe = 1, DmWData = 64'h55, RegWrite = 0 out; next instruction accepted the cycle after the ack.
- Two loads back-to-back, zero-wait -> two WbValid pulses 2 cycles apart, no duplicate access.
- rst_n low in the second ACCESS cycle -> DmReq = 0 and all outputs 0 after that edge; no WbValid for the aborted load.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no DmAck -> MemErr pulses after 4 ACCESS cycles; RegWrite = 0, state back to IDLE.
